fsm_vend: RTL and testbench
===========================

Name: fsm_vend

Overview:
- Parametrised vending controller and successor to the two-coin seller FSM.
- Accepts four coin denominations, all counted in half-unit credits (0.5 ¥ = 1 credit).
- Vends when accumulated credit reaches PRICE.
- Returns change or a full refund serially, one half-unit pulse per cycle, so a downstream coin hopper can be driven directly.
- Also rejects coins that would overflow the credit register or that arrive while the machine is busy.

Parameters:
- CREDIT_W, 4, width of the credit register in half-units.
- PRICE, 3, item price in half-units (3 = 1.5 ¥). Legal range is 1..MAX_CREDIT.
- MAX_CREDIT, 15, maximum credit that may be held. Must satisfy MAX_CREDIT < 2^CREDIT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  a coin is present this cycle.
- coin_code  in  2  coin denomination: 0 = 0.5 ¥ (1 credit), 1 = 1 ¥ (2 credits), 2 = 2 ¥ (4 credits), 3 = 5 ¥ (10 credits).
- cancel  in  1  user requests a refund.
- sell_flag  out  1  one-cycle pulse meaning dispense the item.
- change_pulse  out  1  one-cycle pulse meaning return 0.5 ¥. Asserted on consecutive cycles for multi-unit change.
- coin_reject  out  1  one-cycle pulse meaning the coin was not accepted and must be returned mechanically.
- credit  out  CREDIT_W  current credit register value.
- busy  out  1  high in the VEND and CHANGE states.

Behaviour:
- Reset: while rst is high, the block is asynchronously forced to state IDLE with credit = 0 and sell_flag, change_pulse, coin_reject and busy all 0.
  - Reset mid-vend or mid-change discards the remaining credit.
  - No pulse is emitted after reset.
- Outputs: all outputs are registered. There are no combinational input-to-output paths.
- States:
  - IDLE: credit = 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND.
  - CHANGE.
  - The state encoding is one-hot, 4 bits.
- Coin accept (IDLE or COLLECT, coin_valid = 1, cancel = 0). Let v be the decoded credit value and n = credit + v, computed at CREDIT_W+1 bits.
  - If n > MAX_CREDIT: coin_reject = 1 in the next cycle, credit is unchanged and the state is unchanged.
  - Otherwise, in the next cycle credit = n and the state is:
    - VEND if n >= PRICE;
    - COLLECT otherwise.
  - Accept latency is 1 cycle.
- VEND (lasts exactly 1 cycle):
  - sell_flag = 1 during this cycle.
  - On exit, credit <= credit - PRICE.
  - Next state is CHANGE if the remainder is greater than 0, otherwise IDLE.
- CHANGE:
  - change_pulse = 1 on every cycle spent in CHANGE.
  - credit is decremented by 1 each cycle.
  - When credit reaches 0, the next state is IDLE and change_pulse drops in that same cycle.
  - For a remainder r, there are exactly r consecutive pulses.
- Cancel:
  - In COLLECT: next state is CHANGE and the full credit is refunded. sell_flag is not asserted.
  - In IDLE: ignored.
  - In VEND or CHANGE: ignored (a vend already committed is not aborted).
- Simultaneous cancel and coin in COLLECT: cancel wins and the coin is rejected (coin_reject = 1 next cycle). The same applies in IDLE: the coin is rejected and the state stays IDLE.
- Coin while busy (coin_valid in VEND or CHANGE): coin_reject = 1 next cycle and credit is unaffected.
- Exact price: PRICE = 3 with credit 2 plus a 0.5 ¥ coin goes VEND → IDLE with no change pulses.
- Large overpay: the 5 ¥ coin from IDLE (n = 10) vends and then produces 7 change pulses.
- Illegal state: any state not in the one-hot set recovers to IDLE with credit = 0 and no pulses.

Test Plan (all with default parameters):
1. Reset asserted mid-CHANGE (credit = 5) → outputs clear immediately, credit = 0, IDLE, no further change_pulse.
2. 0.5 ¥ then 1 ¥ on separate cycles → credit 1 then 3; sell_flag high for exactly 1 cycle; 0 change pulses; return to IDLE.
3. Single 5 ¥ coin → credit = 10 next cycle; sell_flag pulse; 7 consecutive change_pulse cycles with credit counting 7..1; then IDLE with credit = 0.
4. 1 ¥ then cancel → 2 change_pulse cycles; sell_flag stays 0; IDLE.
5. 0.5 ¥, 0.5 ¥, then 5 ¥ with MAX_CREDIT = 10 (n = 12) → coin_reject pulse; credit stays 2; a following 0.5 ¥ vends normally.
6. coin_valid asserted during VEND and during CHANGE → coin_reject pulse each time; the change count stays exactly the remainder; cancel together with a coin in COLLECT gives a refund plus coin_reject.

Source files
------------

// File: rtl/fsm_vend_if.sv
// fsm_vend_if: coin/cancel inputs and dispense/change/reject outputs of the vending controller
interface fsm_vend_if #(parameter int CREDIT_W = 4);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                cancel;
    logic                sell_flag;
    logic                change_pulse;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    modport master (output coin_valid, coin_code, cancel,
                    input  sell_flag, change_pulse, coin_reject, busy, credit);
    modport slave  (input  coin_valid, coin_code, cancel,
                    output sell_flag, change_pulse, coin_reject, busy, credit);
endinterface

// File: rtl/fsm_vend.sv
// fsm_vend: half-unit credit vending controller with serial change/refund pulses
module fsm_vend #(
    parameter int CREDIT_W   = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 15
) (
    input logic        clk,
    input logic        rst,
    fsm_vend_if.slave  bus
);
    localparam logic [3:0] IDLE    = 4'b0001;
    localparam logic [3:0] COLLECT = 4'b0010;
    localparam logic [3:0] VEND    = 4'b0100;
    localparam logic [3:0] CHANGE  = 4'b1000;
    localparam logic [CREDIT_W:0]   PRICE_N = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_N   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic [3:0]          state, nxt;
    logic [CREDIT_W-1:0] credit_q, cr_nxt;
    logic [CREDIT_W:0]   v, n;
    logic                rej_nxt;

    assign v = bus.coin_code == 2'd0 ? (CREDIT_W+1)'(1) :
               bus.coin_code == 2'd1 ? (CREDIT_W+1)'(2) :
               bus.coin_code == 2'd2 ? (CREDIT_W+1)'(4) : (CREDIT_W+1)'(10);
    assign n = {1'b0, credit_q} + v;
    assign bus.credit = credit_q;

    // cancel takes priority over a simultaneous coin, which is then rejected
    always_comb begin
        nxt     = state;
        cr_nxt  = credit_q;
        rej_nxt = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (bus.cancel) begin
                    rej_nxt = bus.coin_valid;
                    nxt     = state == COLLECT ? CHANGE : IDLE;
                end else if (bus.coin_valid) begin
                    if (n > MAX_N) rej_nxt = 1'b1;
                    else begin
                        cr_nxt = n[CREDIT_W-1:0];
                        nxt    = n >= PRICE_N ? VEND : COLLECT;
                    end
                end
            end
            VEND: begin
                rej_nxt = bus.coin_valid;
                cr_nxt  = credit_q - PRICE_C;
                nxt     = cr_nxt != '0 ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_nxt = bus.coin_valid;
                cr_nxt  = credit_q - 1'b1;
                nxt     = credit_q == CREDIT_W'(1) ? IDLE : CHANGE;
            end
            default: begin
                nxt    = IDLE;
                cr_nxt = '0;
            end
        endcase
    end

    // pulse outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            credit_q         <= '0;
            bus.sell_flag    <= 1'b0;
            bus.change_pulse <= 1'b0;
            bus.coin_reject  <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            state            <= nxt;
            credit_q         <= cr_nxt;
            bus.sell_flag    <= nxt == VEND;
            bus.change_pulse <= nxt == CHANGE;
            bus.coin_reject  <= rej_nxt;
            bus.busy         <= nxt == VEND || nxt == CHANGE;
        end
    end
endmodule

// File: tb/tb_fsm_vend.sv
// tb_fsm_vend: randomized + directed scoreboard bench for fsm_vend
module tb_fsm_vend;
    localparam int CW = 4, PRICE = 3, MAXC = 10;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    fsm_vend_if #(.CREDIT_W(CW)) bus();
    fsm_vend #(.CREDIT_W(CW), .PRICE(PRICE), .MAX_CREDIT(MAXC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {int cyc; logic sell; logic chg; logic rej; int credit;} ev_t;
    typedef struct {int cyc; int credit; logic busy;} cr_t;
    typedef struct {logic sell; logic chg; int credit;} out_t;

    ev_t  evq[$];
    cr_t  crq[$];
    out_t sched[$];
    ev_t  e_m;
    int   cyc = 0, errors = 0, checks = 0;
    int   m_credit = 0;
    logic m_busy = 1'b0;
    int   coin_val[4] = '{1, 2, 4, 10};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // monitor: compares per-cycle credit/busy and every expected pulse event
    always @(negedge clk) if (!rst) begin
        if (crq.size() > 0 && crq[0].cyc == cyc) begin
            chk("credit", int'(bus.credit), crq[0].credit);
            chk("busy", int'(bus.busy), int'(crq[0].busy));
            void'(crq.pop_front());
        end
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            e_m = evq.pop_front();
            chk("sell_flag", int'(bus.sell_flag), int'(e_m.sell));
            chk("change_pulse", int'(bus.change_pulse), int'(e_m.chg));
            chk("coin_reject", int'(bus.coin_reject), int'(e_m.rej));
            chk("event_credit", int'(bus.credit), e_m.credit);
        end else if (bus.sell_flag || bus.change_pulse || bus.coin_reject) begin
            checks++;
            errors++;
            $display("FAIL spurious_pulse cyc=%0d actual sell=%0b chg=%0b rej=%0b expected none",
                     cyc, bus.sell_flag, bus.change_pulse, bus.coin_reject);
        end
    end

    // reference model: a purchase or refund expands into a precomputed timeline of outputs
    task automatic step(input logic cv, input logic [1:0] code, input logic cn);
        out_t o;
        logic rej;
        int   n;
        @(negedge clk);
        bus.coin_valid = cv;
        bus.coin_code  = code;
        bus.cancel     = cn;
        rej = 1'b0;
        o = '{1'b0, 1'b0, m_credit};
        if (m_busy) begin
            rej = cv;
            if (sched.size() > 0) o = sched.pop_front();
            else o = '{1'b0, 1'b0, 0};
        end else if (cn) begin
            rej = cv;
            if (m_credit > 0) begin
                for (int k = m_credit; k >= 1; k--) sched.push_back('{1'b0, 1'b1, k});
                m_credit = 0;
                o = sched.pop_front();
            end
        end else if (cv) begin
            n = m_credit + coin_val[code];
            if (n > MAXC) rej = 1'b1;
            else if (n >= PRICE) begin
                sched.push_back('{1'b1, 1'b0, n});
                for (int k = n - PRICE; k >= 1; k--) sched.push_back('{1'b0, 1'b1, k});
                m_credit = 0;
                o = sched.pop_front();
            end else begin
                m_credit = n;
                o.credit = n;
            end
        end
        m_busy = o.sell || o.chg;
        crq.push_back('{cyc + 1, o.credit, m_busy});
        if (o.sell || o.chg || rej) evq.push_back('{cyc + 1, o.sell, o.chg, rej, o.credit});
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 2'd0, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_credit"}, int'(bus.credit), 0);
        chk({tag, "_sell"}, int'(bus.sell_flag), 0);
        chk({tag, "_chg"}, int'(bus.change_pulse), 0);
        chk({tag, "_rej"}, int'(bus.coin_reject), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_cleared("rst_mid");
        evq.delete();
        crq.delete();
        sched.delete();
        m_credit = 0;
        m_busy = 1'b0;
        bus.coin_valid = 1'b0;
        bus.cancel = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_code  = 2'd0;
        bus.cancel     = 1'b0;
        @(posedge clk);
        #2 check_cleared("rst_init");
        @(negedge clk);
        rst = 1'b0;
        // 0.5 then 1: exact price, no change
        step(1'b1, 2'd0, 1'b0); step(1'b1, 2'd1, 1'b0); idle(3);
        // 5 yuan: vend then 7 change pulses
        step(1'b1, 2'd3, 1'b0); idle(10);
        // 1 yuan then cancel: 2 refund pulses
        step(1'b1, 2'd1, 1'b0); step(1'b0, 2'd0, 1'b1); idle(4);
        // overflow reject, then normal vend
        step(1'b1, 2'd0, 1'b0); step(1'b1, 2'd0, 1'b0); step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd0, 1'b0); idle(3);
        // coins while busy, then cancel together with coin
        step(1'b1, 2'd3, 1'b0); step(1'b1, 2'd0, 1'b0); step(1'b1, 2'd2, 1'b0); idle(9);
        step(1'b1, 2'd0, 1'b0); step(1'b1, 2'd1, 1'b1); idle(3);
        // cancel and coin in IDLE
        step(1'b1, 2'd2, 1'b1); idle(2);
        // reset in the middle of change, credit 5
        step(1'b1, 2'd3, 1'b0); idle(3);
        do_reset();
        idle(4);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
        idle(14);
        @(negedge clk);
        #1 chk("leftover_events", evq.size(), 0);
        chk("leftover_credit", crq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
